serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial ripple adder. One full-adder cell is reused over WIDTH cycles, LSB first, with a registered carry loop.
- Sits directly around the full-adder cell:
  - feeds it the operand LSBs and the stored carry;
  - consumes its sum and carry outputs into a result shift register and the carry flip-flop.
- Trades latency for area in the datapath. Start/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepted start edge
- b  input  WIDTH  operand B; captured on the accepted start edge
- cin  input  1  carry-in; captured on the accepted start edge
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse
- sum  output  WIDTH  result; valid from the done cycle and held until the next accepted start
- cout  output  1  final carry; same validity as sum

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, shift registers=0, carry=0, bit counter=0.
  - busy=0, done=0, sum=0, cout=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at a rising edge: load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, state<=RUN.
  - Otherwise hold; sum/cout keep their last values.
- RUN, each edge:
  - The full-adder cell computes s/c from a_sr[0], b_sr[0] and carry.
  - sum_sr <= {s, sum_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right by 1 (zero fill).
  - carry<=c, cnt<=cnt+1.
  - When cnt==WIDTH-1 on this edge: state<=DONE.
- DONE:
  - done=1 for exactly one cycle; sum=sum_sr, cout=carry.
  - Next edge: state<=IDLE, unconditionally.
- Latency: start accepted at edge E0; bits processed at edges E1..E_WIDTH; done high in the cycle after E_WIDTH. That is WIDTH+1 edges from start to done.
- Throughput: a new start is accepted no earlier than the IDLE cycle following DONE, i.e. one operation per WIDTH+2 cycles.
- start while busy=1 (RUN or DONE): ignored. Latched operands are unaffected. No queueing.
- a/b/cin changes after the accepted edge have no effect.
- Counter width: $clog2(WIDTH)+1 bits; it never wraps within an operation.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag; signed overflow is the consumer's concern.
- sum/cout outputs:
  - Registered. They update only on the RUN->DONE transition.
  - Intermediate partial sums are never visible on sum.
- Reset asserted mid-RUN or in DONE: immediate return to IDLE; all outputs cleared. No done pulse for the aborted operation.
- done and busy are driven from state/registers only, with no combinational path from start.

Decomposition:
- Shared package/header: state encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10; default WIDTH constant.
- One sub-module: a single instance of the existing fullAdder cell (a, b, cin -> sum, carry). All remaining logic is inline.

Test Plan (WIDTH=8):
- a=8'h5A, b=8'h3C, cin=0, start pulse -> done exactly 9 edges later, sum=8'h96, cout=0; busy high for 9 cycles.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (full carry ripple through all bits).
- a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1. Also a=0, b=0, cin=0 -> sum=0, cout=0.
- start re-pulsed with a=8'h11 at cycle 3 of an operation on 8'h5A+8'h3C -> ignored; result still 8'h96/0; single done pulse.
- rst_n low at cycle 4 of RUN -> busy/done/sum/cout=0 immediately; no done afterward. A new start with 8'h01+8'h02 then gives 8'h03.
- Back-to-back: start held high continuously -> operations complete every 10 cycles. Each result is correct for the operands present at its accepted edge. sum holds between done pulses.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encodings, the default
// operand width, and the bit-counter sizing rule.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned STATE_W       = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'b00;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'b01;
  localparam logic [STATE_W-1:0] ST_DONE = 2'b10;

  // The counter needs one extra bit so it can reach WIDTH without wrapping.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cell reused by the serial adder every cycle.
// Ports:
//   a, b, cin : operand bits and carry-in
//   sum       : a ^ b ^ cin
//   carry     : majority(a, b, cin)
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell processes the operands LSB
// first over WIDTH cycles, with the carry held in a flip-flop between bits.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : request pulse, accepted only while idle
//   a, b, cin  : operands and carry-in, captured on the accepted start edge
//   busy       : high while an operation is running or completing
//   done       : one-cycle completion pulse
//   sum, cout  : result, valid from done until the next accepted start
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  logic [STATE_W-1:0] state_q,  state_d;
  logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic               carry_q,  carry_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [WIDTH-1:0]   sum_q,    sum_d;
  logic               cout_q,   cout_d;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] sum_shift;

  // Shared full-adder cell fed from the operand LSBs and the stored carry.
  serial_adder_fa u_fa (
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .cin   (carry_q),
    .sum   (fa_s),
    .carry (fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign sum_shift = WIDTH'({fa_s, sum_sr_q} >> 1);

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_sr_d = sum_shift;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = fa_c;
        cnt_d    = cnt_q + CNT_W'(1);
        // Last bit: publish the result directly so partial sums stay hidden.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
          sum_d   = sum_shift;
          cout_d  = fa_c;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder with WIDTH=8.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Runs one operation; reports result at done, latency in edges counting the
  // accepted edge, busy cycles, done pulses and partial sums seen before done.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        output logic [7:0] s, output logic co, output int lat,
                        output int busy_cyc, output int done_cnt, output int early);
    logic [7:0] prev;
    s = 8'hxx; co = 1'bx; lat = 0; busy_cyc = 0; done_cnt = 0; early = 0;
    @(negedge clk);
    prev = sum;
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~av; b = ~bv; cin = ~cv;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        if (lat == 0) begin
          lat = i + 1;
          s = sum;
          co = cout;
        end
      end else if (busy && sum !== prev) begin
        early++;
      end
      if (!busy && i > 0) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    #12;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (sum !== 8'h00) $display("FAIL reset_sum: got %h want 00", sum); else pass_cnt++;
    total_cnt++; if (cout !== 1'b0) $display("FAIL reset_cout: got %b want 0", cout); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] s; logic co; int lat, bc, dc, early;
    run_op(8'h5A, 8'h3C, 1'b0, s, co, lat, bc, dc, early);
    total_cnt++; if (s !== 8'h96) $display("FAIL basic_sum: got %h want 96", s); else pass_cnt++;
    total_cnt++; if (co !== 1'b0) $display("FAIL basic_cout: got %b want 0", co); else pass_cnt++;
    total_cnt++; if (lat !== 9) $display("FAIL basic_latency: got %0d want 9", lat); else pass_cnt++;
    total_cnt++; if (bc !== 9) $display("FAIL basic_busy_cycles: got %0d want 9", bc); else pass_cnt++;
    total_cnt++; if (dc !== 1) $display("FAIL basic_done_pulses: got %0d want 1", dc); else pass_cnt++;
    total_cnt++; if (early !== 0) $display("FAIL basic_partial_visible: got %0d want 0", early); else pass_cnt++;
    total_cnt++; if (sum !== 8'h96) $display("FAIL basic_sum_hold: got %h want 96", sum); else pass_cnt++;
  endtask

  task automatic test_carry();
    logic [7:0] s; logic co; int lat, bc, dc, early;
    run_op(8'hFF, 8'h01, 1'b0, s, co, lat, bc, dc, early);
    total_cnt++; if ({co, s} !== 9'h100) $display("FAIL ripple_ff_01: got %b/%h want 1/00", co, s); else pass_cnt++;
    run_op(8'hFF, 8'hFF, 1'b1, s, co, lat, bc, dc, early);
    total_cnt++; if ({co, s} !== 9'h1FF) $display("FAIL max_ff_ff_1: got %b/%h want 1/ff", co, s); else pass_cnt++;
    run_op(8'h00, 8'h00, 1'b0, s, co, lat, bc, dc, early);
    total_cnt++; if ({co, s} !== 9'h000) $display("FAIL zero: got %b/%h want 0/00", co, s); else pass_cnt++;
    run_op(8'h7F, 8'h00, 1'b1, s, co, lat, bc, dc, early);
    total_cnt++; if ({co, s} !== 9'h080) $display("FAIL cin_7f_00_1: got %b/%h want 0/80", co, s); else pass_cnt++;
    total_cnt++; if (early !== 0) $display("FAIL cin_partial_visible: got %0d want 0", early); else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    logic [7:0] s; logic co; int lat, dc;
    s = 8'hxx; co = 1'bx; lat = 0; dc = 0;
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) begin
        a = 8'h11; b = 8'h11; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dc++;
        if (lat == 0) begin lat = i + 1; s = sum; co = cout; end
      end
      if (!busy && i > 0) break;
    end
    start = 1'b0;
    total_cnt++; if ({co, s} !== 9'h096) $display("FAIL ignored_start_result: got %b/%h want 0/96", co, s); else pass_cnt++;
    total_cnt++; if (dc !== 1) $display("FAIL ignored_start_done_pulses: got %0d want 1", dc); else pass_cnt++;
    total_cnt++; if (lat !== 9) $display("FAIL ignored_start_latency: got %0d want 9", lat); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] s; logic co; int lat, bc, dc, early, late_done;
    late_done = 0;
    @(negedge clk);
    a = 8'hA5; b = 8'h5A; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({busy, done, cout, sum} !== 11'h000)
      $display("FAIL midrun_reset_clear: got busy=%b done=%b cout=%b sum=%h want all 0", busy, done, cout, sum);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    total_cnt++; if (late_done !== 0) $display("FAIL midrun_no_done_after: got %0d active cycles want 0", late_done); else pass_cnt++;
    run_op(8'h01, 8'h02, 1'b0, s, co, lat, bc, dc, early);
    total_cnt++; if ({co, s} !== 9'h003) $display("FAIL after_reset_op: got %b/%h want 0/03", co, s); else pass_cnt++;
    total_cnt++; if (lat !== 9) $display("FAIL after_reset_latency: got %0d want 9", lat); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic       tc [3];
    logic [8:0] texp [3];
    logic [8:0] last;
    int done_cnt, bad_timing, hold_err;
    ta[0] = 8'h12; tb[0] = 8'h34; tc[0] = 1'b0; texp[0] = 9'h046;
    ta[1] = 8'h80; tb[1] = 8'h80; tc[1] = 1'b1; texp[1] = 9'h101;
    ta[2] = 8'hC8; tb[2] = 8'h64; tc[2] = 1'b0; texp[2] = 9'h12C;
    done_cnt = 0; bad_timing = 0; hold_err = 0;
    last = {cout, sum};
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (n > 0) begin
        if (done) begin
          done_cnt++;
          if (n % 10 != 9) begin
            bad_timing++;
          end else begin
            total_cnt++;
            if ({cout, sum} !== texp[n/10])
              $display("FAIL b2b_result_%0d: got %b/%h want %b/%h", n/10, cout, sum, texp[n/10][8], texp[n/10][7:0]);
            else pass_cnt++;
          end
          last = {cout, sum};
        end else if ({cout, sum} !== last) begin
          hold_err++;
        end
      end
      start = 1'b1;
      if (n % 10 == 0) begin
        a = ta[n/10]; b = tb[n/10]; cin = tc[n/10];
      end else begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end
    end
    start = 1'b0;
    total_cnt++; if (done_cnt !== 3) $display("FAIL b2b_done_count: got %0d want 3", done_cnt); else pass_cnt++;
    total_cnt++; if (bad_timing !== 0) $display("FAIL b2b_done_spacing: got %0d misplaced want 0", bad_timing); else pass_cnt++;
    total_cnt++; if (hold_err !== 0) $display("FAIL b2b_sum_hold: got %0d changes want 0", hold_err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    repeat (12) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
